// File: rtl/cache_sa_wb_if.sv
// Bus bundle for cache_sa_wb: CPU request/response side plus AXI-bridge read/write side.
// With CACHE_UNCACHED_EN defined it also carries the per-request uncached flag.
interface cache_sa_wb_if #(
    parameter int unsigned LINE_W = 128
);
    logic              valid;
    logic              we;
    logic [31:0]       addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;
`ifdef CACHE_UNCACHED_EN
    logic              uncached;
`endif
    logic              rd_req;
    logic [2:0]        rd_type;
    logic [31:0]       rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic              ret_last;
    logic [31:0]       ret_data;
    logic              wr_req;
    logic [2:0]        wr_type;
    logic [31:0]       wr_addr;
    logic [3:0]        wr_wstrb;
    logic [LINE_W-1:0] wr_data;
    logic              wr_rdy;

    // Cache side
    modport slave (
`ifdef CACHE_UNCACHED_EN
        input  uncached,
`endif
        input  valid, we, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        output addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data
    );

    // CPU + bridge side
    modport master (
`ifdef CACHE_UNCACHED_EN
        output uncached,
`endif
        output valid, we, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        input  addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data
    );
endinterface

// File: rtl/cache_sa_wb.sv
// N-way set-associative write-back/write-allocate blocking cache, one outstanding request.
// Optional CACHE_UNCACHED_EN adds uncached word reads/writes that bypass the arrays.
module cache_sa_wb #(
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned OFFSET_W = 4,
    parameter int unsigned WAY_W    = 1
) (
    input  logic          clk,
    input  logic          reset,
    cache_sa_wb_if.slave  bus
);
    localparam int unsigned SETS   = 2 ** INDEX_W;
    localparam int unsigned WAYS   = 2 ** WAY_W;
    localparam int unsigned WORD_W = OFFSET_W - 2;
    localparam int unsigned TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W = 32 * (2 ** WORD_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS, S_REPLACE, S_REFILL, S_UC_RD, S_UC_RWAIT, S_UC_WR
    } state_t;

    state_t               r_state;
    logic                 r_we;
    logic [31:0]          r_addr;
    logic [3:0]           r_wstrb;
    logic [31:0]          r_wdata;
    logic [WAY_W-1:0]     r_victim;
    logic [WORD_W-1:0]    r_beat;
    logic [WAYS-1:0]      r_valid [SETS];
    logic [WAYS-1:0]      r_dirty [SETS];
    logic [WAY_W-1:0]     r_rr    [SETS];
    logic [TAG_W-1:0]     r_tag   [WAYS][SETS];
    logic [LINE_W-1:0]    r_data  [WAYS][SETS];

    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_idx;
    logic [WORD_W-1:0]    w_word;
    logic                 w_hit;
    logic [WAY_W-1:0]     w_hit_way;
    logic [WAY_W-1:0]     w_victim;
    logic                 w_inv_found;
    logic [LINE_W-1:0]    w_hit_line;
    logic [LINE_W-1:0]    w_vic_line;
    logic [31:0]          w_hit_word;
    logic [31:0]          w_vic_word;
    logic                 w_arr_we;
    logic [WAY_W-1:0]     w_arr_way;
    logic [WORD_W-1:0]    w_arr_word;
    logic [31:0]          w_arr_wdata;
    logic                 w_tag_we;
    logic                 w_req_uc;

    assign w_tag  = r_addr[31:OFFSET_W+INDEX_W];
    assign w_idx  = r_addr[OFFSET_W +: INDEX_W];
    assign w_word = r_addr[2 +: WORD_W];

`ifdef CACHE_UNCACHED_EN
    assign w_req_uc = bus.uncached;
`else
    assign w_req_uc = 1'b0;
`endif

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    // Tag compare and victim choice: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_victim    = r_rr[w_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!w_inv_found && !r_valid[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_victim    = WAY_W'(w);
            end
        end
    end

    assign w_hit_line = r_data[w_hit_way][w_idx];
    assign w_vic_line = r_data[r_victim][w_idx];
    assign w_hit_word = w_hit_line[{w_word, 5'b0} +: 32];
    assign w_vic_word = w_vic_line[{w_word, 5'b0} +: 32];

    // Single array write port: write-hit merge in LOOKUP, beat fill in REFILL
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_way   = r_victim;
        w_arr_word  = r_beat;
        w_arr_wdata = bus.ret_data;
        w_tag_we    = 1'b0;
        case (r_state)
            S_LOOKUP: begin
                if (w_hit && r_we) begin
                    w_arr_we    = 1'b1;
                    w_arr_way   = w_hit_way;
                    w_arr_word  = w_word;
                    w_arr_wdata = merge_bytes(w_hit_word, r_wdata, r_wstrb);
                end
            end
            S_REFILL: begin
                if (bus.ret_valid) begin
                    w_arr_we = 1'b1;
                    w_tag_we = bus.ret_last;
                    if (r_we && (r_beat == w_word))
                        w_arr_wdata = merge_bytes(bus.ret_data, r_wdata, r_wstrb);
                end
            end
            default: ;
        endcase
        if (reset) begin
            w_arr_we = 1'b0;
            w_tag_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_arr_we)
            r_data[w_arr_way][w_idx][{w_arr_word, 5'b0} +: 32] <= w_arr_wdata;
        if (w_tag_we)
            r_tag[r_victim][w_idx] <= w_tag;
    end

    // Control FSM plus valid/dirty/round-robin state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
            r_victim <= '0;
            r_beat   <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wstrb <= bus.wstrb;
                        r_wdata <= bus.wdata;
                        if (w_req_uc) r_state <= bus.we ? S_UC_WR : S_UC_RD;
                        else          r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_victim <= w_victim;
                        r_state  <= (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                                    ? S_MISS : S_REPLACE;
                    end
                end
                S_MISS: begin
                    if (bus.wr_rdy) r_state <= S_REPLACE;
                end
                S_REPLACE: begin
                    if (bus.rd_rdy) begin
                        // Victim line is overwritten beat by beat, so it stops being valid now
                        r_valid[w_idx][r_victim] <= 1'b0;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_beat  <= '0;
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus.ret_valid) begin
                        r_beat <= r_beat + WORD_W'(1);
                        if (bus.ret_last) begin
                            r_valid[w_idx][r_victim] <= 1'b1;
                            r_dirty[w_idx][r_victim] <= r_we;
                            r_rr[w_idx]              <= r_rr[w_idx] + WAY_W'(1);
                            r_state                  <= S_IDLE;
                        end
                    end
                end
                S_UC_RD:    if (bus.rd_rdy)    r_state <= S_UC_RWAIT;
                S_UC_RWAIT: if (bus.ret_valid) r_state <= S_IDLE;
                S_UC_WR:    if (bus.wr_rdy)    r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // Bus outputs decoded from the registered state; response signals follow the cycle's inputs
    always_comb begin
        bus.addr_ok  = bus.valid && (r_state == S_IDLE);
        bus.data_ok  = 1'b0;
        bus.rdata    = '0;
        bus.rd_req   = 1'b0;
        bus.rd_type  = 3'b000;
        bus.rd_addr  = '0;
        bus.wr_req   = 1'b0;
        bus.wr_type  = 3'b000;
        bus.wr_addr  = '0;
        bus.wr_wstrb = '0;
        bus.wr_data  = '0;
        case (r_state)
            S_LOOKUP: begin
                if (w_hit) begin
                    bus.data_ok = 1'b1;
                    if (!r_we) bus.rdata = w_hit_word;
                end
            end
            S_MISS: begin
                bus.wr_req   = 1'b1;
                bus.wr_type  = 3'b100;
                bus.wr_addr  = {r_tag[r_victim][w_idx], w_idx, {OFFSET_W{1'b0}}};
                bus.wr_wstrb = 4'hf;
                bus.wr_data  = w_vic_line;
            end
            S_REPLACE: begin
                bus.rd_req  = 1'b1;
                bus.rd_type = 3'b100;
                bus.rd_addr = {w_tag, w_idx, {OFFSET_W{1'b0}}};
            end
            S_REFILL: begin
                if (bus.ret_valid && bus.ret_last) begin
                    bus.data_ok = 1'b1;
                    if (!r_we) bus.rdata = (r_beat == w_word) ? bus.ret_data : w_vic_word;
                end
            end
            S_UC_RD: begin
                bus.rd_req  = 1'b1;
                bus.rd_type = 3'b010;
                bus.rd_addr = r_addr;
            end
            S_UC_RWAIT: begin
                if (bus.ret_valid) begin
                    bus.data_ok = 1'b1;
                    bus.rdata   = bus.ret_data;
                end
            end
            S_UC_WR: begin
                bus.wr_req   = 1'b1;
                bus.wr_type  = 3'b010;
                bus.wr_addr  = r_addr;
                bus.wr_wstrb = r_wstrb;
                bus.wr_data  = LINE_W'(r_wdata);
                bus.data_ok  = bus.wr_rdy;
            end
            default: ;
        endcase
        if (reset) bus.addr_ok = 1'b0;
    end
endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed self-checking bench for cache_sa_wb (2-way, 256 sets, 16-byte lines) with a
// cycle-level bridge responder; uncached cases run when CACHE_UNCACHED_EN is defined.
`timescale 1ns/1ps
module tb_cache_sa_wb;
    localparam int unsigned LINE_W = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_sa_wb_if #(.LINE_W(LINE_W)) bus ();

    cache_sa_wb #(.INDEX_W(8), .OFFSET_W(4), .WAY_W(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned       n_tests = 0;
    int unsigned       n_fail  = 0;
    logic [31:0]       line_mem [4];
    logic [31:0]       o_rdata;
    int                o_lat;
    int                o_nrd;
    int                o_nwr;
    logic [31:0]       o_rd_addr;
    logic [2:0]        o_rd_type;
    logic [31:0]       o_wr_addr;
    logic [2:0]        o_wr_type;
    logic [3:0]        o_wr_strb;
    logic [LINE_W-1:0] o_wr_data;
    logic              o_ok;
    logic              o_aborted;
    logic              o_both = 1'b0;
`ifdef CACHE_UNCACHED_EN
    logic              req_uc = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_line(input logic [31:0] base);
        for (int k = 0; k < 4; k++) line_mem[k] = base + 32'(k);
    endtask

    // One CPU access; the bridge accepts requests at once and returns beats back to back.
    // abort_beat >= 0 asserts reset alongside that refill beat.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] wdata, input int abort_beat);
        int   beat;
        int   nbeats;
        logic refill;
        logic done;
        o_rdata = '0; o_lat = 0; o_nrd = 0; o_nwr = 0; o_ok = 1'b0; o_aborted = 1'b0;
        o_rd_addr = '0; o_rd_type = '0; o_wr_addr = '0; o_wr_type = '0;
        o_wr_strb = '0; o_wr_data = '0;
        @(negedge clk);
        bus.valid = 1'b1; bus.we = we; bus.addr = addr; bus.wstrb = strb; bus.wdata = wdata;
`ifdef CACHE_UNCACHED_EN
        bus.uncached = req_uc;
`endif
        bus.rd_rdy = 1'b0; bus.wr_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
        #1;
        check_eq("addr_ok", 128'(bus.addr_ok), 128'd1);
        refill = 1'b0; beat = 0; nbeats = 0; done = 1'b0;
        for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
            @(negedge clk);
            bus.valid = 1'b0; bus.rd_rdy = 1'b0; bus.wr_rdy = 1'b0;
            bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = '0;
            if (bus.rd_req && bus.wr_req) o_both = 1'b1;
            if (refill) begin
                bus.ret_valid = 1'b1;
                bus.ret_data  = line_mem[beat];
                bus.ret_last  = (beat == nbeats - 1);
                if (beat == abort_beat) begin
                    reset     = 1'b1;
                    o_aborted = 1'b1;
                end
                beat++;
            end else if (bus.rd_req) begin
                o_nrd++;
                o_rd_addr   = bus.rd_addr;
                o_rd_type   = bus.rd_type;
                nbeats      = (bus.rd_type == 3'b100) ? 4 : 1;
                bus.rd_rdy  = 1'b1;
                refill      = 1'b1;
            end
            if (bus.wr_req) begin
                o_nwr++;
                o_wr_addr  = bus.wr_addr;
                o_wr_type  = bus.wr_type;
                o_wr_strb  = bus.wr_wstrb;
                o_wr_data  = bus.wr_data;
                bus.wr_rdy = 1'b1;
            end
            #1;
            if (bus.data_ok) begin
                o_ok    = 1'b1;
                o_rdata = bus.rdata;
                o_lat   = cyc;
                done    = 1'b1;
            end
            if (o_aborted) done = 1'b1;
        end
        check_eq("access_done", 128'(done), 128'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.valid = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wstrb = '0; bus.wdata = '0;
        bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = '0;
        bus.wr_rdy = 1'b0;
`ifdef CACHE_UNCACHED_EN
        bus.uncached = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rd_req",  128'(bus.rd_req),  128'd0);
        check_eq("rst_wr_req",  128'(bus.wr_req),  128'd0);
        check_eq("rst_data_ok", 128'(bus.data_ok), 128'd0);
        check_eq("rst_addr_ok", 128'(bus.addr_ok), 128'd0);
        check_eq("rst_rdata",   128'(bus.rdata),   128'd0);
        @(negedge clk);
        reset = 1'b0;

        // Cold read miss: line burst, word 0 returned
        set_line(32'hA0A0_0000);
        do_access(1'b0, 32'h0000_1000, 4'h0, 32'h0, -1);
        check_eq("t1_nrd",     128'(o_nrd),     128'd1);
        check_eq("t1_rd_addr", 128'(o_rd_addr), 128'h1000);
        check_eq("t1_rd_type", 128'(o_rd_type), 128'(3'b100));
        check_eq("t1_nwr",     128'(o_nwr),     128'd0);
        check_eq("t1_rdata",   128'(o_rdata),   128'hA0A0_0000);

        // Read hit, one-cycle latency
        do_access(1'b0, 32'h0000_1008, 4'h0, 32'h0, -1);
        check_eq("t2_lat",   128'(o_lat),   128'd1);
        check_eq("t2_nrd",   128'(o_nrd),   128'd0);
        check_eq("t2_rdata", 128'(o_rdata), 128'hA0A0_0002);

        // Partial write hit then read back
        do_access(1'b1, 32'h0000_1004, 4'b0011, 32'hDEAD_BEEF, -1);
        check_eq("t3_wlat", 128'(o_lat), 128'd1);
        check_eq("t3_wnrd", 128'(o_nrd), 128'd0);
        do_access(1'b0, 32'h0000_1004, 4'h0, 32'h0, -1);
        check_eq("t3_rdata", 128'(o_rdata), 128'hA0A0_BEEF);

        // Fill way 1 of set 0, then evict dirty way 0
        set_line(32'hB0B0_0000);
        do_access(1'b0, 32'h0000_2000, 4'h0, 32'h0, -1);
        check_eq("t4a_nwr",   128'(o_nwr),   128'd0);
        check_eq("t4a_rdata", 128'(o_rdata), 128'hB0B0_0000);
        set_line(32'hC0C0_0000);
        do_access(1'b0, 32'h0000_3000, 4'h0, 32'h0, -1);
        check_eq("t4b_nwr",     128'(o_nwr),     128'd1);
        check_eq("t4b_wr_addr", 128'(o_wr_addr), 128'h1000);
        check_eq("t4b_wr_type", 128'(o_wr_type), 128'(3'b100));
        check_eq("t4b_wr_strb", 128'(o_wr_strb), 128'hf);
        check_eq("t4b_wr_data", o_wr_data, 128'hA0A0_0003_A0A0_0002_A0A0_BEEF_A0A0_0000);
        check_eq("t4b_rd_addr", 128'(o_rd_addr), 128'h3000);
        check_eq("t4b_rdata",   128'(o_rdata),   128'hC0C0_0000);
        // Pointer now at way 1: way 1 (tag 2) still hits, next miss evicts it cleanly
        do_access(1'b0, 32'h0000_2000, 4'h0, 32'h0, -1);
        check_eq("t4c_lat",   128'(o_lat),   128'd1);
        check_eq("t4c_rdata", 128'(o_rdata), 128'hB0B0_0000);
        set_line(32'hA0A0_0000);
        do_access(1'b0, 32'h0000_1000, 4'h0, 32'h0, -1);
        check_eq("t4d_nwr", 128'(o_nwr), 128'd0);
        check_eq("t4d_nrd", 128'(o_nrd), 128'd1);
        set_line(32'hB0B0_0000);
        do_access(1'b0, 32'h0000_2000, 4'h0, 32'h0, -1);
        check_eq("t4e_nrd", 128'(o_nrd), 128'd1);
        do_access(1'b0, 32'h0000_1000, 4'h0, 32'h0, -1);
        check_eq("t4f_lat",   128'(o_lat),   128'd1);
        check_eq("t4f_rdata", 128'(o_rdata), 128'hA0A0_0000);

        // Write miss: requested word merged on arrival
        set_line(32'hD0D0_0000);
        do_access(1'b1, 32'h0000_4008, 4'b1100, 32'h1234_5678, -1);
        check_eq("t4g_ok",      128'(o_ok),      128'd1);
        check_eq("t4g_rd_addr", 128'(o_rd_addr), 128'h4000);
        check_eq("t4g_nwr",     128'(o_nwr),     128'd0);
        do_access(1'b0, 32'h0000_4008, 4'h0, 32'h0, -1);
        check_eq("t4h_lat",   128'(o_lat),   128'd1);
        check_eq("t4h_rdata", 128'(o_rdata), 128'h1234_0002);

        // Reset during refill beat 2
        set_line(32'hE0E0_0000);
        do_access(1'b0, 32'h0000_5040, 4'h0, 32'h0, 2);
        check_eq("t5_aborted", 128'(o_aborted), 128'd1);
        check_eq("t5_no_ok",   128'(o_ok),      128'd0);
        @(posedge clk);
        #1;
        check_eq("t5_rd_req",  128'(bus.rd_req),  128'd0);
        check_eq("t5_wr_req",  128'(bus.wr_req),  128'd0);
        check_eq("t5_data_ok", 128'(bus.data_ok), 128'd0);
        @(negedge clk);
        reset = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
        do_access(1'b0, 32'h0000_5040, 4'h0, 32'h0, -1);
        check_eq("t5_re_nrd",   128'(o_nrd),   128'd1);
        check_eq("t5_re_rdata", 128'(o_rdata), 128'hE0E0_0000);
        set_line(32'hD0D0_0000);
        do_access(1'b0, 32'h0000_4008, 4'h0, 32'h0, -1);
        check_eq("t5_old_nrd",   128'(o_nrd),   128'd1);
        check_eq("t5_old_rdata", 128'(o_rdata), 128'hD0D0_0002);

`ifdef CACHE_UNCACHED_EN
        // Uncached word write/read leave cached lines untouched
        req_uc = 1'b1;
        do_access(1'b1, 32'hBFAF_0000, 4'hf, 32'hCAFE_F00D, -1);
        check_eq("t6_nwr",     128'(o_nwr),     128'd1);
        check_eq("t6_wr_type", 128'(o_wr_type), 128'(3'b010));
        check_eq("t6_wr_addr", 128'(o_wr_addr), 128'hBFAF_0000);
        check_eq("t6_wr_strb", 128'(o_wr_strb), 128'hf);
        check_eq("t6_wr_data", o_wr_data,       128'hCAFE_F00D);
        check_eq("t6_ok",      128'(o_ok),      128'd1);
        check_eq("t6_nrd",     128'(o_nrd),     128'd0);
        req_uc = 1'b0;
        set_line(32'hF0F0_0000);
        do_access(1'b0, 32'hBFAF_0000, 4'h0, 32'h0, -1);
        check_eq("t6_c_nrd",     128'(o_nrd),     128'd1);
        check_eq("t6_c_rd_type", 128'(o_rd_type), 128'(3'b100));
        req_uc = 1'b1;
        set_line(32'h5555_0000);
        do_access(1'b0, 32'hBFAF_0010, 4'h0, 32'h0, -1);
        check_eq("t6_u_rd_type", 128'(o_rd_type), 128'(3'b010));
        check_eq("t6_u_rd_addr", 128'(o_rd_addr), 128'hBFAF_0010);
        check_eq("t6_u_rdata",   128'(o_rdata),   128'h5555_0000);
        req_uc = 1'b0;
        do_access(1'b0, 32'hBFAF_0000, 4'h0, 32'h0, -1);
        check_eq("t6_h_lat",   128'(o_lat),   128'd1);
        check_eq("t6_h_rdata", 128'(o_rdata), 128'hF0F0_0000);
`endif

        check_eq("rd_wr_exclusive", 128'(o_both), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
